// File: rtl/video_ddr_pkg.sv
// Shared types and defaults for the video DDR read arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: the one-hot FSM state encoding, default bus widths, and a
// clog2 helper used to size grant indices.
package video_ddr_pkg;

    localparam int DEF_ADDR_WIDTH = 28;
    localparam int DEF_LEN_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH = 128;

    // One-hot FSM states for the read arbiter.
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_REQ  = 4'b0010,
        ST_DATA = 4'b0100,
        ST_END  = 4'b1000
    } state_t;

    // Ceiling log2. Returns 0 for n <= 1; callers clamp to at least 1 bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_prio_arbiter.sv
// Masked-priority pick: first requester at or above ptr, wrapping to 0.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   req      N-bit request vector
//   ptr      starting index of the search (tie to 0 for fixed priority)
//   gnt      one-hot winner, all-zero when nothing requests
//   gnt_idx  binary index of the winner
//   gnt_vld  some channel won
module rr_prio_arbiter
    import video_ddr_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int   k;
    logic found;

    // Walk N positions starting at ptr; the first active request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
    end

    assign gnt_vld = found;

endmodule

// File: rtl/video_ddr_rd_arbiter.sv
// Shares one DDR read port between CH_NUM scaling channels, one burst at a time.
// Latency: request -> o_ddr_rd_req 1 cycle; DDR beat -> o_ch_rd_valid 1 cycle; burst end -> next req 3 cycles.
// Backpressure: channels hold i_ch_req until o_ch_ack; o_ddr_rd_req is held until i_ddr_rd_ack; beats are not stallable.
//
// Build option: ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of the default round-robin.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_ch_req/addr/len   per-channel burst request, packed ch k at [k*W +: W]
//   o_ch_ack            one-cycle pulse when the channel's burst is accepted
//   o_ch_rd_valid/data  one-hot beat strobe and shared read data (registered)
//   o_ch_done           one-cycle pulse with the channel's last beat
//   o_ddr_rd_req/addr/len, i_ddr_rd_ack   DDR request handshake
//   i_ddr_rd_valid/data DDR returned beats
//   o_err               sticky: a beat arrived while no burst was receiving data
module video_ddr_rd_arbiter
    import video_ddr_pkg::*;
#(
    parameter int CH_NUM     = 2,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CH_NUM-1:0]            i_ch_req,
    input  logic [CH_NUM*ADDR_WIDTH-1:0] i_ch_addr,
    input  logic [CH_NUM*LEN_WIDTH-1:0]  i_ch_len,
    output logic [CH_NUM-1:0]            o_ch_ack,
    output logic [CH_NUM-1:0]            o_ch_rd_valid,
    output logic [DATA_WIDTH-1:0]        o_ch_rd_data,
    output logic [CH_NUM-1:0]            o_ch_done,
    output logic                         o_ddr_rd_req,
    output logic [ADDR_WIDTH-1:0]        o_ddr_rd_addr,
    output logic [LEN_WIDTH-1:0]         o_ddr_rd_len,
    input  logic                         i_ddr_rd_ack,
    input  logic                         i_ddr_rd_valid,
    input  logic [DATA_WIDTH-1:0]        i_ddr_rd_data,
    output logic                         o_err
);

    localparam int IDX_W = (clog2(CH_NUM) < 1) ? 1 : clog2(CH_NUM);

    state_t                state;
    logic [IDX_W-1:0]      grant_idx;
    logic [CH_NUM-1:0]     grant_oh;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [CH_NUM-1:0]     rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [CH_NUM-1:0]     done_q;
    logic                  err_q;

    logic [IDX_W-1:0]      arb_ptr;
    logic [CH_NUM-1:0]     arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_vld;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [CH_NUM-1:0]     zero_len_hit;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
    // Search always starts at channel 0, so the lowest index wins.
    assign arb_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr;

    // Pointer moves past the channel just served, once its burst completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state == ST_END) begin
            rr_ptr <= (int'(grant_idx) == CH_NUM - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    assign arb_ptr = rr_ptr;
`endif

    rr_prio_arbiter #(
        .N     (CH_NUM),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (i_ch_req),
        .ptr     (arb_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign sel_addr = i_ch_addr[int'(arb_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_len  = i_ch_len[int'(arb_idx) * LEN_WIDTH +: LEN_WIDTH];

    // A zero-length burst is answered immediately (ack + done together) while
    // still idle. It must be combinational: the requester drops i_ch_req on the
    // ack edge, so a registered pulse would let the same request re-arbitrate.
    assign zero_len_hit = (rst_n && state == ST_IDLE && arb_vld && sel_len == '0) ? arb_gnt : '0;

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant_idx  <= '0;
            grant_oh   <= '0;
            burst_addr <= '0;
            burst_len  <= '0;
            beat_cnt   <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= '0;
            done_q     <= '0;

            case (state)
                ST_IDLE: begin
                    // Address and length are captured here only, so later
                    // changes on the channel inputs cannot disturb the burst.
                    if (arb_vld && sel_len != '0) begin
                        grant_idx  <= arb_idx;
                        grant_oh   <= arb_gnt;
                        burst_addr <= sel_addr;
                        burst_len  <= sel_len;
                        beat_cnt   <= '0;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_ddr_rd_ack) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (i_ddr_rd_valid) begin
                        rd_valid_q <= grant_oh;
                        rd_data_q  <= i_ddr_rd_data;
                        if (beat_cnt == burst_len - 1'b1) begin
                            done_q   <= grant_oh;
                            beat_cnt <= '0;
                            state    <= ST_END;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_END: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Beats with no burst receiving them are dropped and flagged.
            if (i_ddr_rd_valid && state != ST_DATA) begin
                err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_ddr_rd_req  = (state == ST_REQ);
    assign o_ddr_rd_addr = burst_addr;
    assign o_ddr_rd_len  = burst_len;

    // Ack for a real burst follows the DDR ack in the same cycle.
    assign o_ch_ack      = ({CH_NUM{state == ST_REQ && i_ddr_rd_ack}} & grant_oh) | zero_len_hit;
    assign o_ch_rd_valid = rd_valid_q;
    assign o_ch_rd_data  = rd_data_q;
    assign o_ch_done     = done_q | zero_len_hit;
    assign o_err         = err_q;

endmodule

// File: tb/tb_video_ddr_rd_arbiter.sv
module tb_video_ddr_rd_arbiter;

    localparam int CH = 2;
    localparam int AW = 28;
    localparam int LW = 8;
    localparam int DW = 128;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH-1:0]    i_ch_req;
    logic [CH*AW-1:0] i_ch_addr;
    logic [CH*LW-1:0] i_ch_len;
    logic [CH-1:0]    o_ch_ack;
    logic [CH-1:0]    o_ch_rd_valid;
    logic [DW-1:0]    o_ch_rd_data;
    logic [CH-1:0]    o_ch_done;
    logic             o_ddr_rd_req;
    logic [AW-1:0]    o_ddr_rd_addr;
    logic [LW-1:0]    o_ddr_rd_len;
    logic             i_ddr_rd_ack;
    logic             i_ddr_rd_valid;
    logic [DW-1:0]    i_ddr_rd_data;
    logic             o_err;

    always #5 clk = ~clk;

    video_ddr_rd_arbiter #(
        .CH_NUM     (CH),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ch_req       (i_ch_req),
        .i_ch_addr      (i_ch_addr),
        .i_ch_len       (i_ch_len),
        .o_ch_ack       (o_ch_ack),
        .o_ch_rd_valid  (o_ch_rd_valid),
        .o_ch_rd_data   (o_ch_rd_data),
        .o_ch_done      (o_ch_done),
        .o_ddr_rd_req   (o_ddr_rd_req),
        .o_ddr_rd_addr  (o_ddr_rd_addr),
        .o_ddr_rd_len   (o_ddr_rd_len),
        .i_ddr_rd_ack   (i_ddr_rd_ack),
        .i_ddr_rd_valid (i_ddr_rd_valid),
        .i_ddr_rd_data  (i_ddr_rd_data),
        .o_err          (o_err)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [CH-1:0] vld;
        logic [DW-1:0] dat;
        logic [CH-1:0] done;
    } beat_t;

    beat_t sbq[$];
    beat_t mon_e;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every forwarded beat must match the next expected one.
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1 && o_ch_rd_valid !== '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_beat", DW'(o_ch_rd_valid), '0);
            end else begin
                mon_e = sbq.pop_front();
                chk("beat_valid", DW'(o_ch_rd_valid), DW'(mon_e.vld));
                chk("beat_data", o_ch_rd_data, mon_e.dat);
                chk("beat_done", DW'(o_ch_done), DW'(mon_e.done));
            end
        end
    end

    task automatic set_ch(input int ch, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        i_ch_addr[ch*AW +: AW] = addr;
        i_ch_len[ch*LW +: LW]  = len;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, DW'(o_ch_ack), '0);
        chk({tag, "_rd_valid"}, DW'(o_ch_rd_valid), '0);
        chk({tag, "_rd_data"}, o_ch_rd_data, '0);
        chk({tag, "_done"}, DW'(o_ch_done), '0);
        chk({tag, "_ddr_req"}, DW'(o_ddr_rd_req), '0);
        chk({tag, "_ddr_addr"}, DW'(o_ddr_rd_addr), '0);
        chk({tag, "_ddr_len"}, DW'(o_ddr_rd_len), '0);
        chk({tag, "_err"}, DW'(o_err), '0);
    endtask

    // DDR side of one burst: wait for the request, ack after ack_dly extra
    // cycles, then return nbeats beats (the burst is len long). wcnt is the
    // number of cycles from the call until o_ddr_rd_req was seen.
    task automatic serve(input int ack_dly, input int nbeats, input int len,
                         input logic [CH-1:0] exp_ch, input logic [AW-1:0] exp_addr,
                         input logic [CH-1:0] drop, input bit scramble, output int wcnt);
        int               w;
        bit               seen;
        logic [CH*AW-1:0] sa;
        logic [CH*LW-1:0] sl;
        logic [DW-1:0]    d;
        w    = 0;
        seen = 1'b0;
        while (!seen && w < 20) begin
            @(negedge clk);
            #1;
            w++;
            seen = (o_ddr_rd_req === 1'b1);
        end
        wcnt = w;
        if (!seen) begin
            chk("req_timeout", DW'(o_ddr_rd_req), DW'(1));
            return;
        end
        chk("ddr_len", DW'(o_ddr_rd_len), DW'(len));
        sa = i_ch_addr;
        sl = i_ch_len;
        if (scramble) begin
            i_ch_addr = ~i_ch_addr;
            i_ch_len  = ~i_ch_len;
        end
        for (int i = 0; i <= ack_dly; i++) begin
            if (i > 0) begin
                @(negedge clk);
            end
            i_ddr_rd_ack = (i == ack_dly);
            #1;
            chk("req_held", DW'(o_ddr_rd_req), DW'(1));
            chk("ddr_addr", DW'(o_ddr_rd_addr), DW'(exp_addr));
            chk("ch_ack", DW'(o_ch_ack), (i == ack_dly) ? DW'(exp_ch) : '0);
        end
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            if (b == 0) begin
                i_ddr_rd_ack = 1'b0;
                i_ch_req     = i_ch_req & ~drop;
                i_ch_addr    = sa;
                i_ch_len     = sl;
            end
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            i_ddr_rd_valid = 1'b1;
            i_ddr_rd_data  = d;
            sbq.push_back('{vld: exp_ch, dat: d, done: (b == len - 1) ? exp_ch : '0});
            #1;
            if (b == 0) begin
                chk("req_released", DW'(o_ddr_rd_req), '0);
                chk("ack_single", DW'(o_ch_ack), '0);
            end
        end
        @(negedge clk);
        i_ddr_rd_valid = 1'b0;
        i_ddr_rd_ack   = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
        #1;
        chk("sb_empty", DW'(sbq.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [CH-1:0] exp_g;

        i_ch_req       = '0;
        i_ch_addr      = '0;
        i_ch_len       = '0;
        i_ddr_rd_ack   = 1'b0;
        i_ddr_rd_valid = 1'b0;
        i_ddr_rd_data  = '0;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: both channels request continuously, len=8.
        @(negedge clk);
        set_ch(0, 28'h0001000, 8'd8);
        set_ch(1, 28'h0002000, 8'd8);
        i_ch_req = 2'b11;
        for (int n = 0; n < 4; n++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
            serve(1, 8, 8, exp_g, (exp_g == 2'b01) ? 28'h0001000 : 28'h0002000,
                  (n == 3) ? 2'b11 : 2'b00, 1'b0, w);
            chk("req_gap", DW'(w), (n == 0) ? DW'(1) : DW'(2));
        end
        drain();

        // Single channel: ch0 addr 0x100 len 4, ack on the 3rd request cycle;
        // inputs are scrambled while the burst is in flight.
        @(negedge clk);
        set_ch(0, 28'h0000100, 8'd4);
        i_ch_req = 2'b01;
        serve(2, 4, 4, 2'b01, 28'h0000100, 2'b01, 1'b1, w);
        chk("req_latency", DW'(w), DW'(1));
        drain();

        // Zero-length request on ch1: ack and done together, no DDR request.
        @(negedge clk);
        set_ch(1, 28'h0000abc, 8'd0);
        i_ch_req = 2'b10;
        #1;
        chk("len0_ack", DW'(o_ch_ack), DW'(2'b10));
        chk("len0_done", DW'(o_ch_done), DW'(2'b10));
        chk("len0_noreq", DW'(o_ddr_rd_req), '0);
        @(negedge clk);
        i_ch_req = 2'b00;
        #1;
        chk("len0_ack_off", DW'(o_ch_ack), '0);
        chk("len0_done_off", DW'(o_ch_done), '0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("len0_noreq_later", DW'(o_ddr_rd_req), '0);
        end

        // Stray beat while idle: dropped, sticky error, next burst still works.
        chk("err_clear", DW'(o_err), '0);
        @(negedge clk);
        i_ddr_rd_valid = 1'b1;
        i_ddr_rd_data  = 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa;
        @(negedge clk);
        i_ddr_rd_valid = 1'b0;
        #1;
        chk("stray_not_fwd", DW'(o_ch_rd_valid), '0);
        chk("stray_err", DW'(o_err), DW'(1));
        repeat (3) @(negedge clk);
        #1;
        chk("err_sticky", DW'(o_err), DW'(1));
        set_ch(0, 28'h0000300, 8'd3);
        i_ch_req = 2'b01;
        serve(0, 3, 3, 2'b01, 28'h0000300, 2'b01, 1'b0, w);
        drain();
        chk("err_sticky_after", DW'(o_err), DW'(1));

        // Reset after 5 of 16 beats, then a fresh burst on ch1.
        @(negedge clk);
        set_ch(0, 28'h0000400, 8'd16);
        i_ch_req = 2'b01;
        serve(1, 5, 16, 2'b01, 28'h0000400, 2'b01, 1'b0, w);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        chk("midreset_sb", DW'(sbq.size()), '0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_ch(1, 28'h0000500, 8'd3);
        i_ch_req = 2'b10;
        serve(0, 3, 3, 2'b10, 28'h0000500, 2'b10, 1'b0, w);
        chk("fresh_latency", DW'(w), DW'(1));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
